// File: rtl/systolic_mmu_array.sv
// N x N weight-stationary systolic matrix-multiply unit: y = x * W, one vector per cycle.
// Skew/de-skew are internal; weights are double-buffered and committed by a draining swap FSM.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_RUN    | accepting vectors; a swap request moves to ST_DRAIN or ST_SWAP
// ST_DRAIN  | input blocked until every in-flight vector has left the array
// ST_SWAP   | active <= shadow this cycle, swap_done high, input blocked
module systolic_mmu_array #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wt_valid,
    input  logic [$clog2(N)-1:0]    wt_row,
    input  logic [N*DATA_W-1:0]     wt_data,
    input  logic                    wt_swap,
    output logic                    swap_done,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_W-1:0]     in_data,
    output logic                    out_valid,
    output logic [N*ACC_W-1:0]      out_data,
    output logic                    busy
);

    localparam int RW = $clog2(N);
    localparam int VD = 2 * N;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    state_t                      state;
    logic [VD-1:0]               vld;
    logic                        accept;
    logic                        row_ok;

    logic signed [DATA_W-1:0]    shadow_w   [N][N];
    logic signed [DATA_W-1:0]    shadow_nxt [N][N];
    logic signed [DATA_W-1:0]    active_w   [N][N];

    logic signed [DATA_W-1:0]    x_in    [N];
    logic signed [DATA_W-1:0]    a_h     [N][N];
    logic signed [ACC_W-1:0]     p_v     [N+1][N];
    logic signed [ACC_W-1:0]     col_dsk [N];

    assign accept    = in_valid & in_ready;
    assign row_ok    = ({1'b0, wt_row} < (RW+1)'(N));
    assign out_valid = vld[VD-1];
    assign busy      = (|vld) || (state != ST_RUN);

    // Same-cycle write is merged before a commit, so the swap copies the newest value.
    always_comb begin
        shadow_nxt = shadow_w;
        if (wt_valid && row_ok) begin
            for (int j = 0; j < N; j++) begin
                shadow_nxt[wt_row][j] = wt_data[j*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    shadow_w[i][j] <= '0;
                    active_w[i][j] <= '0;
                end
            end
        end else begin
            shadow_w <= shadow_nxt;
            if (state == ST_SWAP) begin
                active_w <= shadow_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_RUN;
            in_ready  <= 1'b1;
            swap_done <= 1'b0;
            vld       <= '0;
        end else begin
            vld       <= {vld[VD-2:0], accept};
            swap_done <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (wt_swap) begin
                        in_ready <= 1'b0;
                        if ((vld == '0) && !in_valid) begin
                            state     <= ST_SWAP;
                            swap_done <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (vld == '0) begin
                        state     <= ST_SWAP;
                        swap_done <= 1'b1;
                    end
                end
                ST_SWAP: begin
                    state    <= ST_RUN;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= ST_RUN;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Bubbles enter as zero so unaccepted input data never reaches the array.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            x_in[i] = accept ? in_data[i*DATA_W +: DATA_W] : '0;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        if (gi == 0) begin : g_direct
            assign a_h[0][0] = x_in[0];
        end else begin : g_delay
            logic signed [DATA_W-1:0] sr [gi];
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int k = 0; k < gi; k++) sr[k] <= '0;
                end else begin
                    sr[0] <= x_in[gi];
                    for (int k = 1; k < gi; k++) sr[k] <= sr[k-1];
                end
            end
            assign a_h[gi][0] = sr[gi-1];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_pe
            logic signed [2*DATA_W-1:0] a_ext;
            logic signed [2*DATA_W-1:0] w_ext;
            logic signed [2*DATA_W-1:0] prod;
            logic signed [ACC_W-1:0]    p_q;

            assign a_ext = (2*DATA_W)'(a_h[gi][gj]);
            assign w_ext = (2*DATA_W)'(active_w[gi][gj]);
            assign prod  = a_ext * w_ext;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    p_q <= '0;
                end else begin
                    p_q <= p_v[gi][gj] + ACC_W'(prod);
                end
            end
            assign p_v[gi+1][gj] = p_q;

            if (gj < N-1) begin : g_fwd
                logic signed [DATA_W-1:0] a_q;
                always_ff @(posedge clk) begin
                    if (!reset) begin
                        a_q <= '0;
                    end else begin
                        a_q <= a_h[gi][gj];
                    end
                end
                assign a_h[gi][gj+1] = a_q;
            end
        end
    end

    // Column j leaves the bottom row j cycles late; delay the rest to line up.
    for (genvar gj = 0; gj < N; gj++) begin : g_dsk
        localparam int D = N - 1 - gj;
        assign p_v[0][gj] = '0;
        if (D == 0) begin : g_none
            assign col_dsk[gj] = p_v[N][gj];
        end else begin : g_dly
            logic signed [ACC_W-1:0] sr [D];
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int k = 0; k < D; k++) sr[k] <= '0;
                end else begin
                    sr[0] <= p_v[N][gj];
                    for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
                end
            end
            assign col_dsk[gj] = sr[D-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data <= '0;
        end else begin
            for (int j = 0; j < N; j++) begin
                out_data[j*ACC_W +: ACC_W] <= col_dsk[j];
            end
        end
    end

endmodule

// File: tb/tb_systolic_mmu_array.sv
// Directed bench for systolic_mmu_array: N=2 and N=4 instances, scoreboard queues
// checked for data and exact output cycle.
module tb_systolic_mmu_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        wv2, wr2, sw2, iv2;
    logic [31:0] wd2, id2;
    logic        ir2, ov2, sd2, bz2;
    logic [63:0] od2;

    logic         wv4, sw4, iv4;
    logic [1:0]   wr4;
    logic [63:0]  wd4, id4;
    logic         ir4, ov4, sd4, bz4;
    logic [127:0] od4;

    systolic_mmu_array #(.N(2), .DATA_W(16), .ACC_W(32)) dut2 (
        .clk(clk), .reset(reset),
        .wt_valid(wv2), .wt_row(wr2), .wt_data(wd2), .wt_swap(sw2), .swap_done(sd2),
        .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_data(od2), .busy(bz2)
    );

    systolic_mmu_array #(.N(4), .DATA_W(16), .ACC_W(32)) dut4 (
        .clk(clk), .reset(reset),
        .wt_valid(wv4), .wt_row(wr4), .wt_data(wd4), .wt_swap(sw4), .swap_done(sd4),
        .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .out_valid(ov4), .out_data(od4), .busy(bz4)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sd2_cnt = 0;
    int pops4 = 0;
    logic [63:0]  q2[$];
    int           c2[$];
    logic [127:0] q4[$];
    int           c4[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (sd2 === 1'b1) sd2_cnt++;
        if (ov2 === 1'b1) begin
            chk("dut2_out_expected", q2.size() > 0, 1'b1);
            if (q2.size() > 0) begin
                chk("dut2_out_data", od2, q2.pop_front());
                chk("dut2_out_cycle", cyc, c2.pop_front());
            end
        end
        if (ov4 === 1'b1) begin
            chk("dut4_out_expected", q4.size() > 0, 1'b1);
            if (q4.size() > 0) begin
                chk("dut4_out_data", od4, q4.pop_front());
                chk("dut4_out_cycle", cyc, c4.pop_front());
                pops4++;
            end
        end
    end

    task automatic wrow2(input logic row, input logic [15:0] a, input logic [15:0] b);
        wv2 = 1'b1; wr2 = row; wd2 = {b, a};
        step();
        wv2 = 1'b0;
    endtask

    // Swap with an empty pipeline: SWAP is entered on the next edge.
    task automatic swap2();
        sw2 = 1'b1;
        step();
        sw2 = 1'b0;
        chk("swap2_done_pulse", sd2, 1'b1);
        chk("swap2_ready_low", ir2, 1'b0);
        step();
    endtask

    task automatic send2(input logic [15:0] x0, input logic [15:0] x1,
                         input logic [31:0] e0, input logic [31:0] e1, input logic swap);
        int n = 0;
        iv2 = 1'b1; id2 = {x1, x0};
        while (ir2 !== 1'b1 && n < 40) begin step(); n++; end
        chk("send2_ready", ir2, 1'b1);
        if (ir2 === 1'b1) begin
            q2.push_back({e1, e0});
            c2.push_back(cyc + 4);
        end
        sw2 = swap;
        step();
        iv2 = 1'b0; sw2 = 1'b0;
    endtask

    task automatic send4(input int k);
        logic [63:0]  x;
        logic [127:0] e;
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            x[i*16 +: 16] = 16'(k + i);
            e[i*32 +: 32] = 32'(k + i);
        end
        iv4 = 1'b1; id4 = x;
        while (ir4 !== 1'b1 && n < 40) begin step(); n++; end
        chk("send4_ready", ir4, 1'b1);
        if (ir4 === 1'b1) begin
            q4.push_back(e);
            c4.push_back(cyc + 8);
        end
        step();
        iv4 = 1'b0;
    endtask

    task automatic wait_idle2();
        int n = 0;
        while ((q2.size() != 0 || bz2 === 1'b1) && n < 100) begin step(); n++; end
        chk("idle2_in_time", n < 100, 1'b1);
        chk("idle2_busy", bz2, 1'b0);
    endtask

    task automatic wait_idle4();
        int n = 0;
        while ((q4.size() != 0 || bz4 === 1'b1) && n < 100) begin step(); n++; end
        chk("idle4_in_time", n < 100, 1'b1);
        chk("idle4_busy", bz4, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        reset = 1'b0;
        wv2 = 0; wr2 = 0; wd2 = 0; sw2 = 0; iv2 = 0; id2 = 0;
        wv4 = 0; wr4 = 0; wd4 = 0; sw4 = 0; iv4 = 0; id4 = 0;
        repeat (3) step();
        reset = 1'b1;
        step();

        chk("rst_in_ready", ir2, 1'b1);
        chk("rst_out_valid", ov2, 1'b0);
        chk("rst_out_data", od2, 64'h0);
        chk("rst_swap_done", sd2, 1'b0);
        chk("rst_busy", bz2, 1'b0);
        chk("rst4_in_ready", ir4, 1'b1);
        chk("rst4_out_data", od4, 128'h0);

        // W=[[1,2],[3,4]], x=[5,6] -> [23,34], latency 4
        wrow2(1'b0, 16'd1, 16'd2);
        wrow2(1'b1, 16'd3, 16'd4);
        swap2();
        send2(16'd5, 16'd6, 32'd23, 32'd34, 1'b0);
        chk("t1_busy_in_flight", bz2, 1'b1);
        wait_idle2();
        chk("t1_swap_done_count", sd2_cnt, 1);

        // N=4 identity, 10 back-to-back vectors
        for (int i = 0; i < 4; i++) begin
            wv4 = 1'b1; wr4 = 2'(i); wd4 = 64'(1) << (i * 16);
            step();
        end
        wv4 = 1'b0;
        sw4 = 1'b1;
        step();
        sw4 = 1'b0;
        step();
        for (int k = 0; k < 10; k++) send4(k);
        wait_idle4();
        chk("t2_output_count", pops4, 10);

        // mid-stream swap: identity -> 2*identity
        wrow2(1'b0, 16'd1, 16'd0);
        wrow2(1'b1, 16'd0, 16'd1);
        swap2();
        wrow2(1'b0, 16'd2, 16'd0);
        wrow2(1'b1, 16'd0, 16'd2);
        base = sd2_cnt;
        send2(16'd1, 16'd1, 32'd1, 32'd1, 1'b0);
        send2(16'd1, 16'd1, 32'd1, 32'd1, 1'b0);
        send2(16'd1, 16'd1, 32'd1, 32'd1, 1'b1);
        chk("t3_drain_ready_low", ir2, 1'b0);
        chk("t3_drain_busy", bz2, 1'b1);
        send2(16'd1, 16'd1, 32'd2, 32'd2, 1'b0);
        wait_idle2();
        chk("t3_swap_count", sd2_cnt, base + 1);

        // signed products and wrap
        wrow2(1'b0, 16'h8000, 16'h8000);
        wrow2(1'b1, 16'h8000, 16'h8000);
        swap2();
        send2(16'h8000, 16'h8000, 32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_idle2();
        wrow2(1'b0, 16'd1, 16'd1);
        wrow2(1'b1, 16'd1, 16'd1);
        swap2();
        send2(16'hFFFD, 16'd7, 32'd4, 32'd4, 1'b0);
        wait_idle2();

        // shadow writes during a stream leave results untouched
        wrow2(1'b0, 16'd1, 16'd2);
        wrow2(1'b1, 16'd3, 16'd4);
        swap2();
        send2(16'd1, 16'd0, 32'd1, 32'd2, 1'b0);
        wv2 = 1'b1; wr2 = 1'b0; wd2 = {16'd200, 16'd100};
        send2(16'd0, 16'd1, 32'd3, 32'd4, 1'b0);
        wv2 = 1'b0;
        send2(16'd2, 16'd1, 32'd5, 32'd8, 1'b0);
        wait_idle2();

        // write landing in the commit cycle is included in the commit
        sw2 = 1'b1;
        step();
        sw2 = 1'b0;
        chk("t6_swap_cycle", sd2, 1'b1);
        wv2 = 1'b1; wr2 = 1'b1; wd2 = {16'd8, 16'd7};
        step();
        wv2 = 1'b0;
        send2(16'd1, 16'd1, 32'd107, 32'd208, 1'b0);
        wait_idle2();

        // reset with vectors in flight discards them and clears weights
        send2(16'd1, 16'd1, 32'd107, 32'd208, 1'b0);
        send2(16'd1, 16'd1, 32'd107, 32'd208, 1'b0);
        send2(16'd1, 16'd1, 32'd107, 32'd208, 1'b0);
        step();
        reset = 1'b0;
        step();
        q2.delete();
        c2.delete();
        chk("t7_rst_out_valid", ov2, 1'b0);
        chk("t7_rst_out_data", od2, 64'h0);
        chk("t7_rst_busy", bz2, 1'b0);
        chk("t7_rst_in_ready", ir2, 1'b1);
        chk("t7_rst_swap_done", sd2, 1'b0);
        step();
        reset = 1'b1;
        step();
        send2(16'd5, 16'd6, 32'd0, 32'd0, 1'b0);
        wait_idle2();
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_mmu_array.md
Name: systolic_mmu_array

Overview:
- Parametrised N×N weight-stationary systolic matrix-multiply unit, successor to the fixed 2×2 array.
- Accepts one activation row-vector x (N elements) per cycle and produces y = x·W (N accumulators) after a fixed latency.
- Input skew and output de-skew are internal, so callers see aligned vectors on both sides.
- Weights are double-buffered (shadow/active banks); a swap FSM drains in-flight data before committing new weights.

Parameters:
- N, 4, array dimension (rows = columns), ≥2
- DATA_W, 16, signed activation/weight width
- ACC_W, 32, signed accumulator width, ≥2*DATA_W

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- wt_valid  in  1  write wt_data into shadow row wt_row this cycle
- wt_row  in  $clog2(N)  shadow row index i
- wt_data  in  N*DATA_W  W[i][0..N-1], element j at bits [j*DATA_W +: DATA_W]
- wt_swap  in  1  pulse: request shadow→active commit
- swap_done  out  1  one-cycle pulse when commit occurs
- in_valid  in  1  activation vector present
- in_ready  out  1  array accepts vector (accept = in_valid & in_ready)
- in_data  in  N*DATA_W  x[0..N-1], element i at bits [i*DATA_W +: DATA_W]
- out_valid  out  1  result vector valid (no backpressure; must be consumed)
- out_data  out  N*ACC_W  y[0..N-1], element j at bits [j*ACC_W +: ACC_W]
- busy  out  1  any vector in flight or swap pending

Behaviour:
- Reset (reset==0 at clk edge): shadow and active weights = 0, all pipeline/skew/de-skew registers = 0, valid pipeline cleared (in-flight data discarded), FSM = RUN. Outputs: in_ready=1, out_valid=0, out_data=0, swap_done=0, busy=0.
- Math: y[j] = Σ_i x[i]*W[i][j]; signed DATA_W×DATA_W product sign-extended to ACC_W; two's-complement wrap on overflow, no saturation.
- Dataflow: x[i] delayed i cycles (skew) into PE(i,0) and moves right one PE per cycle. Partial sums enter PE(0,j) as 0 and move down one PE per cycle. Column j output is delayed N-1-j cycles (de-skew), then registered.
- Latency: a vector accepted at cycle t produces out_valid=1 with its result at cycle t+2N exactly. Back-to-back accepts give back-to-back outputs, in order. Throughput is 1 vector/cycle.
- Valid tracking: a 2N-deep valid shift register. busy = any bit set OR FSM≠RUN OR swap pending.
- Shadow writes: allowed any cycle, in any state, and never affect in-flight results. Last write to a row before commit wins. wt_valid and swap commit on the same cycle: the write lands in shadow first, and the commit copies the updated value.
- FSM states:
  - RUN: in_ready=1. On wt_swap: if the valid pipeline is empty and in_valid=0, go to SWAP; otherwise go to DRAIN. A vector with in_valid=1 on the wt_swap cycle IS accepted and uses the old weights.
  - DRAIN: in_ready=0. When the valid pipeline is empty, go to SWAP.
  - SWAP: active ← shadow (all N×N) in one cycle; swap_done=1; in_ready=0; next state RUN.
- A wt_swap during DRAIN or SWAP is ignored (no queuing).
- Vectors accepted after swap_done use the new weights. No vector ever sees mixed weights.
- in_valid while in_ready=0: not accepted; the source holds the data.
- wt_row ≥ N (non-power-of-2 N): the write is ignored.

Test Plan:
- N=2, write shadow rows W=[[1,2],[3,4]], swap, then x=[5,6] at cycle t → out_valid at t+4 exactly, out_data=[23,34]; swap_done pulses once.
- N=4, W=identity, stream x=[k,k+1,k+2,k+3] for k=0..9 back-to-back → 10 consecutive out_valid cycles, y equals x in order, first at t0+8.
- Mid-stream swap, N=2: old W=[[1,0],[0,1]], new W=[[2,0],[0,2]]; x=[1,1] every cycle; pulse wt_swap on accept #3 → #1–#3 give [1,1]; in_ready=0 during drain; first vector after swap_done gives [2,2].
- Signed/wrap, N=2, DATA_W=16, ACC_W=32: W all 0x8000, x=[0x8000,0x8000] → each y = 2^31 wraps to 0x80000000. Repeat with x=[-3,7] and W=[[1,1],[1,1]] → y=[4,4].
- Reset asserted (low) 2 cycles after 3 vectors accepted → no out_valid afterwards; all outputs 0; after deassert, x=[5,6] → y=[0,0] (weights cleared).
- Shadow write during stream: write new row 0 while vectors are in flight, with no swap → results unchanged. Simultaneous wt_valid+commit → the new value is used post-swap.
